// File: rtl/bootram_ctrl_pkg.sv
// Shared types and constants for the boot memory controller.
// Lanes are byte-wide; the word address is common to all banks.
package bootram_ctrl_pkg;

  localparam int BOOTRAM_BANKS  = 4;
  localparam int BOOTRAM_ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_t;

  function automatic logic [BOOTRAM_BANKS-1:0] lane_onehot(input logic [1:0] sel);
    logic [BOOTRAM_BANKS-1:0] mask;
    mask = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/bootram_lane_sel.sv
// Per-lane decode of chip enable, write enable and write data for one access.
// Pure combinational; every input comes from controller registers.
module bootram_lane_sel
  import bootram_ctrl_pkg::*;
#(
  parameter int BANKS = BOOTRAM_BANKS
) (
  input  logic               active,
  input  grant_t             grant,
  input  logic [BANKS-1:0]   wstrb,
  input  logic [1:0]         byte_sel,
  input  logic               wr_lock,
  input  logic [8*BANKS-1:0] cpu_wdata,
  input  logic [7:0]         ld_wdata,
  output logic [BANKS-1:0]   ram_ce,
  output logic [BANKS-1:0]   ram_wre,
  output logic [8*BANKS-1:0] ram_din
);

  logic                 is_ld;
  logic                 is_read;
  logic [BANKS-1:0]     ld_mask;
  logic [BANKS-1:0]     lane_hit;

  assign is_ld   = (grant == GRANT_LD);
  assign is_read = !is_ld && (wstrb == '0);
  assign ld_mask = lane_onehot(byte_sel);

  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi = gi + 1) begin : g_lane
      // A CPU read enables every lane; writes enable only the selected lanes.
      assign lane_hit[gi]      = is_ld ? ld_mask[gi] : (is_read || wstrb[gi]);
      assign ram_ce[gi]        = active && lane_hit[gi];
      assign ram_wre[gi]       = active && lane_hit[gi] && !is_read && !wr_lock;
      assign ram_din[8*gi +: 8] = is_ld ? ld_wdata : cpu_wdata[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/bootram_ctrl.sv
// Arbiter and access sequencer for the four-bank boot RAM (CPU port + loader port).
// Bank OCE is tied high and bank RESET tied low where the banks are instantiated.
module bootram_ctrl
  import bootram_ctrl_pkg::*;
#(
  parameter int ADDR_W = BOOTRAM_ADDR_W,
  parameter int BANKS  = BOOTRAM_BANKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic [31:0]        cpu_addr,
  input  logic [8*BANKS-1:0] cpu_wdata,
  input  logic [BANKS-1:0]   cpu_wstrb,
  output logic [8*BANKS-1:0] cpu_rdata,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [ADDR_W+1:0]  ld_addr,
  input  logic [7:0]         ld_wdata,
  input  logic               wr_lock,
  output logic [BANKS-1:0]   ram_ce,
  output logic [BANKS-1:0]   ram_wre,
  output logic [ADDR_W-1:0]  ram_ad,
  output logic [8*BANKS-1:0] ram_din,
  input  logic [8*BANKS-1:0] ram_dout
);

  generate
    if (BANKS != 4) begin : g_banks_check
      $error("bootram_ctrl: BANKS must be 4");
    end
  endgenerate

  state_t               state_reg, state_next;
  grant_t               grant_reg, grant_next;
  grant_t               last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [BANKS-1:0]     wstrb_reg, wstrb_next;
  logic [8*BANKS-1:0]   wdata_reg, wdata_next;
  logic [7:0]           ld_byte_reg, ld_byte_next;
  logic [1:0]           lane_reg, lane_next;
  logic                 lock_reg, lock_next;
  logic [8*BANKS-1:0]   rdata_reg, rdata_next;
  logic                 is_read;
  logic                 addr_unused;

  // Address bits outside the word field are ignored, so the memory aliases.
  assign addr_unused = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  assign is_read = (grant_reg == GRANT_CPU) && (wstrb_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= GRANT_CPU;
      last_grant_reg <= GRANT_CPU;
      addr_reg       <= '0;
      wstrb_reg      <= '0;
      wdata_reg      <= '0;
      ld_byte_reg    <= '0;
      lane_reg       <= '0;
      lock_reg       <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wstrb_reg      <= wstrb_next;
      wdata_reg      <= wdata_next;
      ld_byte_reg    <= ld_byte_next;
      lane_reg       <= lane_next;
      lock_reg       <= lock_next;
      rdata_reg      <= rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wstrb_next      = wstrb_reg;
    wdata_next      = wdata_reg;
    ld_byte_next    = ld_byte_reg;
    lane_next       = lane_reg;
    lock_next       = lock_reg;
    rdata_next      = rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_valid || ld_valid) begin
          // Loader wins when alone, or when both ask and the CPU had the last grant.
          if (ld_valid && (!cpu_valid || last_grant_reg == GRANT_CPU)) begin
            grant_next   = GRANT_LD;
            addr_next    = ld_addr[ADDR_W+1:2];
            lane_next    = ld_addr[1:0];
            ld_byte_next = ld_wdata;
            wstrb_next   = '0;
          end else begin
            grant_next   = GRANT_CPU;
            addr_next    = cpu_addr[ADDR_W+1:2];
            wstrb_next   = cpu_wstrb;
            wdata_next   = cpu_wdata;
          end
          last_grant_next = grant_next;
          // Lock is captured with the request so no input reaches ram_wre directly.
          lock_next  = wr_lock;
          state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        state_next = is_read ? ST_RDATA : ST_DONE;
      end
      ST_RDATA: begin
        rdata_next = ram_dout;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  bootram_lane_sel #(
    .BANKS(BANKS)
  ) u_lane_sel (
    .active    (state_reg == ST_ACC),
    .grant     (grant_reg),
    .wstrb     (wstrb_reg),
    .byte_sel  (lane_reg),
    .wr_lock   (lock_reg),
    .cpu_wdata (wdata_reg),
    .ld_wdata  (ld_byte_reg),
    .ram_ce    (ram_ce),
    .ram_wre   (ram_wre),
    .ram_din   (ram_din)
  );

  assign ram_ad    = addr_reg;
  assign cpu_rdata = rdata_reg;
  assign cpu_ready = (state_reg == ST_DONE) && (grant_reg == GRANT_CPU);
  assign ld_ready  = (state_reg == ST_DONE) && (grant_reg == GRANT_LD);

endmodule

// File: tb/tb_bootram_ctrl.sv
// Bench for bootram_ctrl: bank model, transaction-level reference model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_bootram_ctrl;
  import bootram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_valid, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        ld_valid, ld_ready;
  logic [12:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        wr_lock;
  logic [3:0]  ram_ce, ram_wre;
  logic [10:0] ram_ad;
  logic [31:0] ram_din, ram_dout;

  int passed = 0;
  int total  = 0;
  int wre_count = 0;
  bit order_q[$];

  always #5 clk = ~clk;

  bootram_ctrl #(.ADDR_W(11), .BANKS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .wr_lock(wr_lock),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Four 2Kx8 banks, bypass read mode, one-cycle synchronous read.
  logic [7:0] bank_mem [0:3][0:2047];
  logic [7:0] bank_q [0:3];
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_ce[n]) begin
        if (ram_wre[n]) begin
          bank_mem[n][ram_ad] <= ram_din[8*n +: 8];
          bank_q[n]           <= ram_din[8*n +: 8];
        end else begin
          bank_q[n] <= bank_mem[n][ram_ad];
        end
      end
    end
  end
  assign ram_dout = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
  endfunction

  // Reference model: one transaction at a time, described by its sampling edge.
  int unsigned edge_k = 0, s_edge = 0, free_edge = 0;
  bit          busy = 0, t_ld = 0, t_read = 0, t_lock = 0, last_ld = 0;
  logic [10:0] t_word;
  logic [1:0]  t_lane;
  logic [3:0]  t_strb;
  logic [31:0] t_data, t_rd;
  logic [7:0]  t_byte;
  logic [7:0]  mmem [0:2047][0:3];
  logic [3:0]  exp_ce = 0, exp_wre = 0, din_mask = 0;
  logic [31:0] exp_din = 0, exp_rdata = 0;
  logic [10:0] exp_ad = 0;
  logic        exp_cpu_ready = 0, exp_ld_ready = 0;
  bit          chk_ad = 0;

  always @(posedge clk) begin
    edge_k++;
    exp_ce = 0; exp_wre = 0; din_mask = 0; exp_din = 0;
    exp_cpu_ready = 0; exp_ld_ready = 0; chk_ad = 0;
    if (reset) begin
      busy = 0; last_ld = 0; free_edge = edge_k + 1; exp_rdata = 0;
    end else begin
      if (edge_k >= free_edge && (cpu_valid || ld_valid)) begin
        t_ld    = ld_valid && (!cpu_valid || !last_ld);
        last_ld = t_ld;
        busy    = 1;
        s_edge  = edge_k;
        t_lock  = wr_lock;
        if (t_ld) begin
          t_word = ld_addr[12:2]; t_lane = ld_addr[1:0]; t_byte = ld_wdata; t_read = 0;
          if (!t_lock) mmem[t_word][t_lane] = t_byte;
        end else begin
          t_word = cpu_addr[12:2]; t_strb = cpu_wstrb; t_data = cpu_wdata;
          t_read = (t_strb == 4'h0);
          if (t_read) t_rd = {mmem[t_word][3], mmem[t_word][2], mmem[t_word][1], mmem[t_word][0]};
          else if (!t_lock)
            for (int b = 0; b < 4; b++) if (t_strb[b]) mmem[t_word][b] = t_data[8*b +: 8];
        end
        free_edge = edge_k + (t_read ? 4 : 3);
      end
      if (busy) begin
        case (edge_k - s_edge)
          0: begin
            chk_ad = 1; exp_ad = t_word;
            if (t_ld) exp_ce = 4'b0001 << t_lane;
            else if (t_read) exp_ce = 4'hF;
            else exp_ce = t_strb;
            exp_wre = (t_read || t_lock) ? 4'h0 : exp_ce;
            if (t_ld) begin din_mask = 4'hF; exp_din = {4{t_byte}}; end
            else if (!t_read) begin din_mask = t_strb; exp_din = t_data; end
          end
          1: if (!t_read) begin exp_cpu_ready = !t_ld; exp_ld_ready = t_ld; end
          2: if (t_read) begin exp_cpu_ready = 1; exp_rdata = t_rd; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] m;
    if (ram_wre != 4'h0) wre_count++;
    if (reset) begin
      chk("rst_outputs", {ram_ce, ram_wre, 22'(ram_ad), cpu_ready, ld_ready}, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_din", ram_din, 32'h0);
    end else begin
      chk("ram_ce", 32'(ram_ce), 32'(exp_ce));
      chk("ram_wre", 32'(ram_wre), 32'(exp_wre));
      chk("readies", {30'h0, cpu_ready, ld_ready}, {30'h0, exp_cpu_ready, exp_ld_ready});
      chk("cpu_rdata", cpu_rdata, exp_rdata);
      if (chk_ad) chk("ram_ad", 32'(ram_ad), 32'(exp_ad));
      if (din_mask != 4'h0) begin
        m = {{8{din_mask[3]}}, {8{din_mask[2]}}, {8{din_mask[1]}}, {8{din_mask[0]}}};
        chk("ram_din", ram_din & m, exp_din & m);
      end
    end
  end

  task automatic cpu_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit keep, output logic [31:0] rd, output int lat);
    @(posedge clk); #2;
    cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_valid = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ready && lat < 40);
    if (!cpu_ready) chk("cpu_ready_timeout", 32'(cpu_ready), 32'h1);
    rd = cpu_rdata;
    order_q.push_back(1'b0);
    if (!keep) begin @(posedge clk); #2; cpu_valid = 1'b0; end
  endtask

  task automatic ld_txn(input logic [12:0] a, input logic [7:0] d, input bit keep,
                        output int lat, output logic [3:0] ce2);
    @(posedge clk); #2;
    ld_addr = a; ld_wdata = d; ld_valid = 1'b1;
    lat = 0; ce2 = 4'h0;
    do begin @(negedge clk); lat++; if (lat == 2) ce2 = ram_ce; end
    while (!ld_ready && lat < 40);
    if (!ld_ready) chk("ld_ready_timeout", 32'(ld_ready), 32'h1);
    order_q.push_back(1'b1);
    if (!keep) begin @(posedge clk); #2; ld_valid = 1'b0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd_a, rd_b, ca, cd;
    logic [3:0]  ce_a, ce_b, cs;
    logic [12:0] la;
    logic [7:0]  ldb;
    logic [7:0]  ld_bytes [0:3];
    int          lat_a, lat_b, w0, mode;
    ld_bytes[0] = 8'h13; ld_bytes[1] = 8'h05; ld_bytes[2] = 8'h10; ld_bytes[3] = 8'h00;
    cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    ld_valid = 0; ld_addr = 0; ld_wdata = 0; wr_lock = 0;

    repeat (3) @(posedge clk);
    #3;
    chk("init_rst_zero", {ram_ce, ram_wre, cpu_ready, ld_ready, 22'(ram_ad)}, 32'h0);
    reset = 1'b0;
    repeat (3) begin @(negedge clk); chk("idle_no_ready", {30'h0, cpu_ready, ld_ready}, 32'h0); end

    for (int i = 0; i < 4; i++) begin
      ld_txn(13'h100 + 13'(i), ld_bytes[i], 1'b0, lat_a, ce_a);
      chk("ld_latency", 32'(lat_a), 32'd3);
      chk("ld_onehot", 32'(ce_a), 32'h1 << i);
    end
    cpu_txn(32'h100, 32'h0, 4'h0, 1'b0, rd_a, lat_a);
    chk("rd_0x100", rd_a, 32'h00100513);
    chk("rd_latency", 32'(lat_a), 32'd4);
    cpu_txn(32'h100, 32'h00AB0000, 4'b0100, 1'b0, rd_a, lat_a);
    chk("wr_latency", 32'(lat_a), 32'd3);
    cpu_txn(32'h100, 32'h0, 4'h0, 1'b0, rd_a, lat_a);
    chk("rd_partial", rd_a, 32'h00AB0513);

    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    order_q.delete();
    fork
      begin
        ld_txn(13'h104, 8'h21, 1'b1, lat_a, ce_a);
        ld_txn(13'h105, 8'h43, 1'b0, lat_a, ce_a);
      end
      begin
        cpu_txn(32'h100, 32'h0, 4'h0, 1'b1, rd_b, lat_b);
        cpu_txn(32'h100, 32'h0, 4'h0, 1'b0, rd_b, lat_b);
      end
    join
    chk("rr_count", 32'(order_q.size()), 32'd4);
    chk("rr_order", {28'h0, order_q[0], order_q[1], order_q[2], order_q[3]}, 32'b1010);

    cpu_txn(32'h200, 32'h11223344, 4'hF, 1'b0, rd_a, lat_a);
    @(posedge clk); #2; wr_lock = 1'b1;
    w0 = wre_count;
    cpu_txn(32'h200, 32'hDEADBEEF, 4'hF, 1'b0, rd_a, lat_a);
    chk("lock_ready_latency", 32'(lat_a), 32'd3);
    chk("lock_no_wre", 32'(wre_count - w0), 32'd0);
    @(posedge clk); #2; wr_lock = 1'b0;
    cpu_txn(32'h200, 32'h0, 4'h0, 1'b0, rd_a, lat_a);
    chk("lock_prior_data", rd_a, 32'h11223344);

    @(posedge clk); #2;
    cpu_addr = 32'h100; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3; reset = 1'b1; cpu_valid = 1'b0;
    #1;
    chk("rdata_rst_zero", {ram_ce, ram_wre, cpu_ready, ld_ready, 22'(ram_ad)}, 32'h0);
    chk("rdata_rst_rdata", cpu_rdata, 32'h0);
    chk("rdata_rst_din", ram_din, 32'h0);
    @(posedge clk); #3; reset = 1'b0;
    repeat (4) begin @(negedge clk); chk("no_ready_after_rst", 32'(cpu_ready), 32'h0); end
    cpu_txn(32'h2100, 32'h0, 4'h0, 1'b0, rd_a, lat_a);
    chk("alias_0x2100", rd_a, 32'h00AB0513);
    chk("alias_latency", 32'(lat_a), 32'd4);

    for (int w = 0; w < 8; w++)
      cpu_txn({19'h0, 11'h40 + 11'(w), 2'b00}, $urandom, 4'hF, 1'b0, rd_a, lat_a);

    for (int it = 0; it < 80; it++) begin
      mode = $urandom_range(0, 3);
      ca = $urandom;
      ca[12:2] = 11'h40 + 11'($urandom_range(0, 7));
      cd = $urandom;
      cs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      la = {11'h40 + 11'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      ldb = 8'($urandom);
      case (mode)
        0: cpu_txn(ca, cd, cs, 1'b0, rd_a, lat_a);
        1: ld_txn(la, ldb, 1'b0, lat_b, ce_b);
        2: fork
             cpu_txn(ca, cd, cs, 1'b0, rd_a, lat_a);
             ld_txn(la, ldb, 1'b0, lat_b, ce_b);
           join
        default: begin
          @(posedge clk); #2; wr_lock = ($urandom_range(0, 2) == 0);
          cpu_txn(ca, cd, cs, 1'b0, rd_a, lat_a);
        end
      endcase
    end
    @(posedge clk); #2; wr_lock = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
